// File: rtl/mem_arbiter.sv
// Three-way arbiter sharing one memory port between an icache refill port and
// separate dcache read/write ports, with starvation relief and access timeout.
module mem_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255,
    parameter logic [2:0] STARVE  = 3'd4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        ireq_i,
    input  logic [31:0] iadr_i,
    output logic [31:0] irdata_o,
    output logic        ival_o,
    output logic        ierr_o,

    input  logic        drreq_i,
    input  logic [31:0] dradr_i,
    input  logic        dwreq_i,
    input  logic [31:0] dwadr_i,
    input  logic [31:0] dwdata_i,
    output logic [31:0] drdata_o,
    output logic        dval_o,
    output logic        derr_o,

    output logic        m_req_o,
    output logic        m_we_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_wdata_o,
    input  logic [31:0] m_rdata_i,
    input  logic        m_val_i,

    output logic [1:0]  owner_o,
    output logic        busy_o
);

    // state  | meaning
    // IDLE   | no transfer; arbitrate on every edge with a request present
    // ACCESS | memory port driven for the owner; wait for m_val or timeout
    // DONE   | one-cycle val/err pulse to the owner, then back to IDLE
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_DR   = 2'd2;
    localparam logic [1:0] OWN_DW   = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_adr_q, m_adr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] irdata_q, irdata_d;
    logic [31:0] drdata_q, drdata_d;
    logic        ival_q, ival_d;
    logic        ierr_q, ierr_d;
    logic        dval_q, dval_d;
    logic        derr_q, derr_d;
    logic        busy_q, busy_d;
    logic [2:0]  starve_q, starve_d;
    logic [7:0]  tmo_q, tmo_d;

    logic        any_req;
    logic        timeout_hit;
    logic [1:0]  grant;
    logic [31:0] grant_adr;

    assign any_req     = ireq_i | drreq_i | dwreq_i;
    assign timeout_hit = (tmo_q == (TIMEOUT - 8'd1));

    // icache overrides the fixed priority once dcache has won STARVE times in a row
    always_comb begin
        grant     = OWN_NONE;
        grant_adr = 32'd0;
        if (ireq_i && (starve_q == STARVE)) begin
            grant     = OWN_I;
            grant_adr = iadr_i;
        end else if (dwreq_i) begin
            grant     = OWN_DW;
            grant_adr = dwadr_i;
        end else if (drreq_i) begin
            grant     = OWN_DR;
            grant_adr = dradr_i;
        end else if (ireq_i) begin
            grant     = OWN_I;
            grant_adr = iadr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (m_val_i || timeout_hit) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        owner_d   = owner_q;
        m_adr_d   = m_adr_q;
        m_wdata_d = m_wdata_q;
        irdata_d  = irdata_q;
        drdata_d  = drdata_q;
        starve_d  = starve_q;
        tmo_d     = 8'd0;
        ival_d    = 1'b0;
        ierr_d    = 1'b0;
        dval_d    = 1'b0;
        derr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!ireq_i) starve_d = 3'd0;
                if (any_req) begin
                    owner_d = grant;
                    m_adr_d = grant_adr;
                    if (grant == OWN_DW) m_wdata_d = dwdata_i;
                    if (grant == OWN_I) begin
                        starve_d = 3'd0;
                    end else if (ireq_i) begin
                        starve_d = (starve_q == STARVE) ? STARVE : starve_q + 3'd1;
                    end
                end
            end
            S_ACCESS: begin
                tmo_d = tmo_q + 8'd1;
                // m_val on the timeout edge still counts as a completion
                if (m_val_i) begin
                    case (owner_q)
                        OWN_I: begin
                            irdata_d = m_rdata_i;
                            ival_d   = 1'b1;
                        end
                        OWN_DR: begin
                            drdata_d = m_rdata_i;
                            dval_d   = 1'b1;
                        end
                        OWN_DW: begin
                            dval_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (timeout_hit) begin
                    case (owner_q)
                        OWN_I: begin
                            irdata_d = 32'd0;
                            ierr_d   = 1'b1;
                        end
                        OWN_DR, OWN_DW: begin
                            drdata_d = 32'd0;
                            derr_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_DONE: begin
                owner_d = OWN_NONE;
            end
            default: begin
                owner_d = OWN_NONE;
            end
        endcase

        m_req_d = (state_d == S_ACCESS);
        m_we_d  = (state_d == S_ACCESS) && (owner_d == OWN_DW);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q   <= OWN_NONE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_adr_q   <= 32'd0;
            m_wdata_q <= 32'd0;
            irdata_q  <= 32'd0;
            drdata_q  <= 32'd0;
            ival_q    <= 1'b0;
            ierr_q    <= 1'b0;
            dval_q    <= 1'b0;
            derr_q    <= 1'b0;
            busy_q    <= 1'b0;
            starve_q  <= 3'd0;
            tmo_q     <= 8'd0;
        end else begin
            owner_q   <= owner_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_adr_q   <= m_adr_d;
            m_wdata_q <= m_wdata_d;
            irdata_q  <= irdata_d;
            drdata_q  <= drdata_d;
            ival_q    <= ival_d;
            ierr_q    <= ierr_d;
            dval_q    <= dval_d;
            derr_q    <= derr_d;
            busy_q    <= busy_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
        end
    end

    assign owner_o   = owner_q;
    assign m_req_o   = m_req_q;
    assign m_we_o    = m_we_q;
    assign m_adr_o   = m_adr_q;
    assign m_wdata_o = m_wdata_q;
    assign irdata_o  = irdata_q;
    assign drdata_o  = drdata_q;
    assign ival_o    = ival_q;
    assign ierr_o    = ierr_q;
    assign dval_o    = dval_q;
    assign derr_o    = derr_q;
    assign busy_o    = busy_q;

endmodule
